coo_aggregate_block: RTL and testbench

//  Combination (aggregation) stage of the GCN pipeline. It sits between the transformation

---
 rtl/coo_aggregate_block.sv | 145 ++++++++++++++
 tb/tb_coo_aggregate_block.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/coo_aggregate_block.sv
// coo_aggregate_block: the aggregation stage of the GCN pipeline.
// It walks a COO edge list of an undirected graph. For each edge (s,d) it
// adds FM_WM row d into ADJ_FM_WM row s, then FM_WM row s into ADJ_FM_WM
// row d. The ADJ_FM_WM result is held in registers.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   done_trans     level input; FM_WM memory is valid, so aggregation starts
//   coo_address    COO entry index being read
//   coo_src/dst    COO entry at coo_address (combinational read)
//   fm_wm_adr      FM_WM row to read
//   fm_wm_row_in   FM_WM row at fm_wm_adr (combinational read)
//   read_row       argmax row select
//   adj_fm_wm_row  ADJ_FM_WM[read_row]; all zeros when read_row is out of range
//   done_comb      sticky completion flag; cleared only by reset
module coo_aggregate_block #(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned WEIGHT_COLS    = 3,
    parameter int unsigned DOT_PROD_WIDTH = 16,
    parameter int unsigned NUM_EDGES      = 6,
    parameter int unsigned COO_BW         = 3,
    parameter int unsigned EDGE_ADR_W     = 3,
    parameter int unsigned ROW_ADR_W      = 3
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        done_trans,
    output logic [EDGE_ADR_W-1:0]                       coo_address,
    input  logic [COO_BW-1:0]                           coo_src,
    input  logic [COO_BW-1:0]                           coo_dst,
    output logic [ROW_ADR_W-1:0]                        fm_wm_adr,
    input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  fm_wm_row_in,
    input  logic [ROW_ADR_W-1:0]                        read_row,
    output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  adj_fm_wm_row,
    output logic                                        done_comb
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SD,
        DS,
        DONE
    } state_t;

    localparam logic [EDGE_ADR_W-1:0] LAST_EDGE = EDGE_ADR_W'(NUM_EDGES - 1);

    state_t                                     state_q, state_d;
    logic [EDGE_ADR_W-1:0]                      cnt_q, cnt_d;
    logic                                       done_q, done_d;
    logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] adj_q [FEATURE_ROWS];
    logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] adj_d [FEATURE_ROWS];

    int unsigned src_i;
    int unsigned dst_i;
    logic        edge_ok;

    // An edge with either endpoint out of range is skipped entirely.
    always_comb begin
        src_i   = 32'(coo_src);
        dst_i   = 32'(coo_dst);
        edge_ok = (src_i < FEATURE_ROWS) && (dst_i < FEATURE_ROWS);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adj_d       = adj_q;
        // done_comb rises one cycle after DONE is entered, then stays set.
        done_d      = done_q | (state_q == DONE);
        coo_address = cnt_q;
        fm_wm_adr   = '0;

        case (state_q)
            IDLE: begin
                if (done_trans) state_d = CLEAR;
            end
            CLEAR: begin
                for (int unsigned r = 0; r < FEATURE_ROWS; r++) adj_d[r] = '0;
                cnt_d   = '0;
                state_d = SD;
            end
            SD: begin
                fm_wm_adr = ROW_ADR_W'(coo_dst);
                if (edge_ok) begin
                    for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
                        if (r == src_i) begin
                            for (int unsigned c = 0; c < WEIGHT_COLS; c++)
                                adj_d[r][c] = adj_q[r][c] + fm_wm_row_in[c];
                        end
                    end
                end
                state_d = DS;
            end
            DS: begin
                fm_wm_adr = ROW_ADR_W'(coo_src);
                // A self-loop was already accumulated once in SD.
                if (edge_ok && (src_i != dst_i)) begin
                    for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
                        if (r == dst_i) begin
                            for (int unsigned c = 0; c < WEIGHT_COLS; c++)
                                adj_d[r][c] = adj_q[r][c] + fm_wm_row_in[c];
                        end
                    end
                end
                if (cnt_q == LAST_EDGE) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + EDGE_ADR_W'(1);
                    state_d = SD;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int unsigned r = 0; r < FEATURE_ROWS; r++) adj_q[r] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            adj_q   <= adj_d;
        end
    end

    always_comb begin
        adj_fm_wm_row = '0;
        for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
            if (32'(read_row) == r) adj_fm_wm_row = adj_q[r];
        end
    end

    assign done_comb = done_q;

endmodule

// File: tb/tb_coo_aggregate_block.sv
// Testbench for coo_aggregate_block. It supplies the COO edge list and the
// FM_WM memory as combinational read arrays, and predicts ADJ_FM_WM from the
// edge list using plain per-edge arithmetic.
module tb_coo_aggregate_block;

    localparam int FR  = 6;
    localparam int WC  = 3;
    localparam int DW  = 16;
    localparam int NE  = 6;
    localparam int CBW = 3;
    localparam int EAW = 3;
    localparam int RAW = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    done_trans;
    logic [EAW-1:0]          coo_address;
    logic [CBW-1:0]          coo_src, coo_dst;
    logic [RAW-1:0]          fm_wm_adr;
    logic [WC-1:0][DW-1:0]   fm_wm_row_in;
    logic [RAW-1:0]          read_row;
    logic [WC-1:0][DW-1:0]   adj_fm_wm_row;
    logic                    done_comb;

    logic [CBW-1:0]          edge_src [8];
    logic [CBW-1:0]          edge_dst [8];
    logic [WC-1:0][DW-1:0]   fm_mem   [8];
    logic [WC-1:0][DW-1:0]   exp_adj  [FR];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign coo_src      = edge_src[coo_address];
    assign coo_dst      = edge_dst[coo_address];
    assign fm_wm_row_in = fm_mem[fm_wm_adr];

    coo_aggregate_block #(
        .FEATURE_ROWS   (FR),
        .WEIGHT_COLS    (WC),
        .DOT_PROD_WIDTH (DW),
        .NUM_EDGES      (NE),
        .COO_BW         (CBW),
        .EDGE_ADR_W     (EAW),
        .ROW_ADR_W      (RAW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .done_trans    (done_trans),
        .coo_address   (coo_address),
        .coo_src       (coo_src),
        .coo_dst       (coo_dst),
        .fm_wm_adr     (fm_wm_adr),
        .fm_wm_row_in  (fm_wm_row_in),
        .read_row      (read_row),
        .adj_fm_wm_row (adj_fm_wm_row),
        .done_comb     (done_comb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Undirected aggregation: each in-range edge adds each endpoint's row into
    // the other; a self-loop contributes its row once.
    task automatic build_model();
        int s, d;
        for (int r = 0; r < FR; r++) exp_adj[r] = '0;
        for (int e = 0; e < NE; e++) begin
            s = int'(edge_src[e]);
            d = int'(edge_dst[e]);
            if (s < FR && d < FR) begin
                for (int c = 0; c < WC; c++) exp_adj[s][c] = exp_adj[s][c] + fm_mem[d][c];
                if (s != d)
                    for (int c = 0; c < WC; c++) exp_adj[d][c] = exp_adj[d][c] + fm_mem[s][c];
            end
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < FR; r++) exp_adj[r] = '0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_rows(input string tag);
        for (int r = 0; r < FR; r++) begin
            read_row = RAW'(r);
            #1 chk($sformatf("%s_row%0d", tag, r), 64'(adj_fm_wm_row), 64'(exp_adj[r]));
        end
        read_row = RAW'(6);
        #1 chk($sformatf("%s_row6", tag), 64'(adj_fm_wm_row), 64'd0);
        read_row = RAW'(7);
        #1 chk($sformatf("%s_row7", tag), 64'(adj_fm_wm_row), 64'd0);
    endtask

    // Starts a run from IDLE; done_trans is sampled at the first edge and
    // dropped right after, so the run must continue on its own.
    task automatic run_agg(input string tag);
        int n;
        bit seen;
        done_trans = 1'b1;
        @(posedge clk);
        #1 done_trans = 1'b0;
        n = 0;
        seen = 0;
        while (n < 100 && !seen) begin
            @(posedge clk);
            #1 n++;
            if (done_comb) seen = 1;
        end
        chk({tag, "_latency"}, 64'(n), 64'd14);
        check_rows(tag);
    endtask

    task automatic load_chain();
        for (int i = 0; i < 8; i++) begin
            fm_mem[i][0] = DW'(i + 1);
            fm_mem[i][1] = DW'(10 * (i + 1));
            fm_mem[i][2] = DW'(100 * (i + 1));
            edge_src[i] = CBW'(i % 6);
            edge_dst[i] = CBW'((i + 1) % 6);
        end
    endtask

    initial begin
        reset = 1'b0;
        done_trans = 1'b0;
        read_row = '0;
        for (int i = 0; i < 8; i++) begin
            fm_mem[i] = '0;
            edge_src[i] = '0;
            edge_dst[i] = '0;
        end

        // Reset state
        @(posedge clk);
        #1 do_reset(3);
        chk("rst_done", 64'(done_comb), 64'd0);
        chk("rst_cooadr", 64'(coo_address), 64'd0);
        chk("rst_fmadr", 64'(fm_wm_adr), 64'd0);
        clear_model();
        check_rows("rst");

        // Ring of six edges
        load_chain();
        build_model();
        chk("ring_model_row0", 64'(exp_adj[0]), {16'd0, 16'd800, 16'd80, 16'd8});
        run_agg("ring");

        // Self-loops on node 2
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            fm_mem[i] = '0;
            edge_src[i] = CBW'(2);
            edge_dst[i] = CBW'(2);
        end
        fm_mem[2] = {16'd300, 16'd30, 16'd3};
        build_model();
        run_agg("self");

        // Modulo wrap plus out-of-range edges
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            fm_mem[i] = '0;
            edge_src[i] = CBW'(7);
            edge_dst[i] = CBW'(7);
        end
        fm_mem[1] = {16'd0, 16'd1, 16'hFFFF};
        edge_src[0] = CBW'(0); edge_dst[0] = CBW'(1);
        edge_src[1] = CBW'(0); edge_dst[1] = CBW'(1);
        build_model();
        chk("wrap_model_row0", 64'(exp_adj[0]), {16'd0, 16'd0, 16'd2, 16'hFFFE});
        run_agg("wrap");

        // Reset during the third DS cycle
        do_reset(2);
        load_chain();
        done_trans = 1'b1;
        @(posedge clk);
        #1 done_trans = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_cooadr", 64'(coo_address), 64'd2);
        chk("mid_fmadr", 64'(fm_wm_adr), 64'd2);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mid_done", 64'(done_comb), 64'd0);
        clear_model();
        check_rows("mid");
        build_model();
        run_agg("rerun");

        // Sticky done and held results
        for (int i = 0; i < 4; i++) begin
            done_trans = ~done_trans;
            @(posedge clk);
            #1 chk($sformatf("sticky_done%0d", i), 64'(done_comb), 64'd1);
        end
        done_trans = 1'b0;
        check_rows("sticky");

        // Random graphs with some out-of-range node IDs
        for (int t = 0; t < 8; t++) begin
            do_reset(2);
            for (int i = 0; i < 8; i++) begin
                for (int c = 0; c < WC; c++) fm_mem[i][c] = DW'($urandom);
                edge_src[i] = CBW'($urandom_range(0, 7));
                edge_dst[i] = CBW'($urandom_range(0, 7));
            end
            build_model();
            run_agg($sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
